// File: rtl/disp_arb_pkg.sv
// ---------------------------------------------------------------------------
// disp_arb_pkg
// Shared definitions for the disp AXI4-Lite arbiter slice:
//   - NUM_REQ           : number of requesters (2)
//   - RESP_*            : AXI4-Lite BRESP/RRESP encodings
//   - disp_arb_state_e  : transaction FSM state encoding
// ---------------------------------------------------------------------------
package disp_arb_pkg;

   localparam int NUM_REQ = 2;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR      = 3'd1,
      ST_WR_RESP = 3'd2,
      ST_RD_ADDR = 3'd3,
      ST_RD_DATA = 3'd4,
      ST_DONE    = 3'd5
   } disp_arb_state_e;

endpackage

// File: rtl/disp_axil_arbiter_if.sv
// ---------------------------------------------------------------------------
// disp_axil_arbiter_if
// AXI4-Lite channel bundle (32-bit data) between the arbiter and the disp
// S00_AXI slave.
//   master modport : drives AW/W/AR valids+payload, BREADY, RREADY
//   slave  modport : drives AWREADY/WREADY/ARREADY, B and R channels
// Handshake rule on every channel: a transfer happens on a rising clock edge
// where VALID and READY are both 1; VALID, once raised, holds with stable
// payload until that edge and never waits on READY.
// ---------------------------------------------------------------------------
interface disp_axil_arbiter_if #(
   parameter int AXI_ADDR_WIDTH = 4
) ();
   logic                      awvalid;
   logic                      awready;
   logic [AXI_ADDR_WIDTH-1:0] awaddr;
   logic [2:0]                awprot;
   logic                      wvalid;
   logic                      wready;
   logic [31:0]               wdata;
   logic [3:0]                wstrb;
   logic                      bvalid;
   logic                      bready;
   logic [1:0]                bresp;
   logic                      arvalid;
   logic                      arready;
   logic [AXI_ADDR_WIDTH-1:0] araddr;
   logic [2:0]                arprot;
   logic                      rvalid;
   logic                      rready;
   logic [31:0]               rdata;
   logic [1:0]                rresp;

   modport master (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/disp_rr_arbiter.sv
// ---------------------------------------------------------------------------
// disp_rr_arbiter
// Two-way round-robin grant. On a tie the grant goes to the requester that
// did not win last; a lone requester always wins. last_grant only moves on
// an accept strobe and resets to 1 so requester 0 wins the first tie.
//   clk_i, rst_i   : clock, async active-high reset
//   req_valid_i    : per-requester request valid
//   accept_i       : the current grant is being taken this cycle
//   grant_o        : index of the winning requester (combinational)
//   any_valid_o    : at least one requester is valid
// ---------------------------------------------------------------------------
module disp_rr_arbiter
   import disp_arb_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_REQ-1:0] req_valid_i,
   input  logic               accept_i,
   output logic               grant_o,
   output logic               any_valid_o
);

   logic last_grant_q, last_grant_d;

   always_comb begin
      if (&req_valid_i) grant_o = ~last_grant_q;
      else              grant_o = req_valid_i[1];
      last_grant_d = last_grant_q;
      if (accept_i) last_grant_d = grant_o;
   end

   assign any_valid_o = |req_valid_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) last_grant_q <= 1'b1;
      else       last_grant_q <= last_grant_d;
   end

endmodule

// File: rtl/disp_axil_arbiter.sv
// ---------------------------------------------------------------------------
// disp_axil_arbiter
// AXI4-Lite master front end for the 4-register disp peripheral. Two
// requesters issue single-word reads/writes; the winner of a round-robin
// arbitration is run as one complete AXI4-Lite transaction and its
// response is returned with a one-cycle done pulse.
//   ACLK, ARESET : clock, async active-high reset
//   req_valid/req_ready/req_we/req_addr/req_wdata : requester side
//   done/rsp_resp/rsp_rdata : completion pulse and response (registered)
//   m_axi        : AXI4-Lite master channels (disp_axil_arbiter_if.master)
//   dbg_state_o  : current FSM state
// Build option: define DISP_ARB_ADDR_CHECK_EN to answer out-of-range word
// indices locally with DECERR instead of wrapping onto req_addr[3:2].
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module disp_axil_arbiter
   import disp_arb_pkg::*;
#(
   parameter int REQ_ADDR_WIDTH = 8,
   parameter int AXI_ADDR_WIDTH = 4,
   parameter int NUM_REGS       = 4
) (
   input  logic                                   ACLK,
   input  logic                                   ARESET,
   input  logic [NUM_REQ-1:0]                     req_valid,
   output logic [NUM_REQ-1:0]                     req_ready,
   input  logic [NUM_REQ-1:0]                     req_we,
   input  logic [NUM_REQ-1:0][REQ_ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ-1:0][31:0]               req_wdata,
   output logic [NUM_REQ-1:0]                     done,
   output logic [1:0]                             rsp_resp,
   output logic [31:0]                            rsp_rdata,
   disp_axil_arbiter_if.master                    m_axi,
   output disp_arb_state_e                        dbg_state_o
);

   disp_arb_state_e           state_q, state_d;
   logic                      gnt_q, gnt_d;
   logic [NUM_REQ-1:0]        req_ready_q, req_ready_d;
   logic [NUM_REQ-1:0]        done_q, done_d;
   logic [1:0]                rsp_resp_q, rsp_resp_d;
   logic [31:0]               rsp_rdata_q, rsp_rdata_d;
   logic                      awvalid_q, awvalid_d;
   logic                      wvalid_q, wvalid_d;
   logic                      bready_q, bready_d;
   logic                      arvalid_q, arvalid_d;
   logic                      rready_q, rready_d;
   logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [31:0]               wdata_q, wdata_d;

   logic                      grant, any_valid, accept;
   logic [AXI_ADDR_WIDTH-1:0] axi_addr;
   logic                      addr_out_of_range;
   logic                      unused_bits;

   disp_rr_arbiter u_rr (
      .clk_i       (ACLK),
      .rst_i       (ARESET),
      .req_valid_i (req_valid),
      .accept_i    (accept),
      .grant_o     (grant),
      .any_valid_o (any_valid)
   );

   // Word-aligned AXI address; bits above the register file are dropped.
   assign axi_addr = {req_addr[grant][AXI_ADDR_WIDTH-1:2], 2'b00};
   assign addr_out_of_range =
      (req_addr[grant][REQ_ADDR_WIDTH-1:2] >= (REQ_ADDR_WIDTH-2)'(NUM_REGS));
   // Byte-offset bits (and, without the range check, the upper bits) are
   // intentionally ignored.
   assign unused_bits = ^{req_addr, addr_out_of_range};

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      req_ready_d = '0;
      done_d      = '0;
      rsp_resp_d  = rsp_resp_q;
      rsp_rdata_d = rsp_rdata_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      awaddr_d    = awaddr_q;
      araddr_d    = araddr_q;
      wdata_d     = wdata_q;
      accept      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (any_valid) begin
               accept             = 1'b1;
               gnt_d              = grant;
               req_ready_d[grant] = 1'b1;
`ifdef DISP_ARB_ADDR_CHECK_EN
               if (addr_out_of_range) begin
                  state_d        = ST_DONE;
                  done_d[grant]  = 1'b1;
                  rsp_resp_d     = RESP_DECERR;
                  rsp_rdata_d    = '0;
               end else
`endif
               if (req_we[grant]) begin
                  state_d   = ST_WR;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  awaddr_d  = axi_addr;
                  wdata_d   = req_wdata[grant];
               end else begin
                  state_d   = ST_RD_ADDR;
                  arvalid_d = 1'b1;
                  araddr_d  = axi_addr;
               end
            end
         end
         ST_WR: begin
            // A channel whose valid is already low has completed earlier.
            if (m_axi.awready) awvalid_d = 1'b0;
            if (m_axi.wready)  wvalid_d  = 1'b0;
            if ((!awvalid_q || m_axi.awready) && (!wvalid_q || m_axi.wready)) begin
               state_d  = ST_WR_RESP;
               bready_d = 1'b1;
            end
         end
         ST_WR_RESP: begin
            if (m_axi.bvalid) begin
               state_d       = ST_DONE;
               bready_d      = 1'b0;
               done_d[gnt_q] = 1'b1;
               rsp_resp_d    = m_axi.bresp;
               rsp_rdata_d   = '0;
            end
         end
         ST_RD_ADDR: begin
            if (m_axi.arready) begin
               state_d   = ST_RD_DATA;
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
            end
         end
         ST_RD_DATA: begin
            if (m_axi.rvalid) begin
               state_d       = ST_DONE;
               rready_d      = 1'b0;
               done_d[gnt_q] = 1'b1;
               rsp_resp_d    = m_axi.rresp;
               rsp_rdata_d   = m_axi.rdata;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q     <= ST_IDLE;
         gnt_q       <= 1'b0;
         req_ready_q <= '0;
         done_q      <= '0;
         rsp_resp_q  <= '0;
         rsp_rdata_q <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         awaddr_q    <= '0;
         araddr_q    <= '0;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         req_ready_q <= req_ready_d;
         done_q      <= done_d;
         rsp_resp_q  <= rsp_resp_d;
         rsp_rdata_q <= rsp_rdata_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         awaddr_q    <= awaddr_d;
         araddr_q    <= araddr_d;
         wdata_q     <= wdata_d;
      end
   end

   assign req_ready     = req_ready_q;
   assign done          = done_q;
   assign rsp_resp      = rsp_resp_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign dbg_state_o   = state_q;

   assign m_axi.awvalid = awvalid_q;
   assign m_axi.awaddr  = awaddr_q;
   assign m_axi.awprot  = 3'b000;
   assign m_axi.wvalid  = wvalid_q;
   assign m_axi.wdata   = wdata_q;
   assign m_axi.wstrb   = 4'hF;
   assign m_axi.bready  = bready_q;
   assign m_axi.arvalid = arvalid_q;
   assign m_axi.araddr  = araddr_q;
   assign m_axi.arprot  = 3'b000;
   assign m_axi.rready  = rready_q;

endmodule

// File: tb/tb_disp_axil_arbiter.sv
// ---------------------------------------------------------------------------
// tb_disp_axil_arbiter
// Directed bench for disp_axil_arbiter with a small reactive AXI4-Lite slave
// (4 x 32-bit registers, programmable AWREADY delay, ARREADY stall, BRESP).
// ---------------------------------------------------------------------------
module tb_disp_axil_arbiter;
   import disp_arb_pkg::*;

   logic             aclk;
   logic             areset;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0]       req_we;
   logic [1:0][7:0]  req_addr;
   logic [1:0][31:0] req_wdata;
   logic [1:0]       done;
   logic [1:0]       rsp_resp;
   logic [31:0]      rsp_rdata;
   disp_arb_state_e  dbg_state;

   disp_axil_arbiter_if #(.AXI_ADDR_WIDTH(4)) axi ();

   disp_axil_arbiter #(
      .REQ_ADDR_WIDTH (8),
      .AXI_ADDR_WIDTH (4),
      .NUM_REGS       (4)
   ) dut (
      .ACLK        (aclk),
      .ARESET      (areset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .done        (done),
      .rsp_resp    (rsp_resp),
      .rsp_rdata   (rsp_rdata),
      .m_axi       (axi.master),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock ----------------
   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   // ---------------- slave model state ----------------
   int          aw_delay;
   logic        ar_stall;
   logic [1:0]  b_resp_cfg;
   logic [3:0]  last_awaddr;
   logic [31:0] last_wdata;
   logic [3:0]  last_wstrb;
   logic [3:0]  last_araddr;
   int          b_cnt;
   logic [31:0] mem [4];

   initial begin : slave
      logic hs_aw, hs_w, hs_b, hs_ar, hs_r;
      logic got_aw, got_w;
      int   aw_cnt;
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
      axi.bresp = 2'b00;  axi.arready = 1'b0; axi.rvalid = 1'b0;
      axi.rdata = '0;     axi.rresp = 2'b00;
      got_aw = 1'b0; got_w = 1'b0; aw_cnt = 0; b_cnt = 0;
      last_awaddr = '0; last_wdata = '0; last_wstrb = '0; last_araddr = '0;
      for (int i = 0; i < 4; i++) mem[i] = '0;
      forever begin
         @(posedge aclk);
         hs_aw = axi.awvalid & axi.awready;
         hs_w  = axi.wvalid  & axi.wready;
         hs_b  = axi.bvalid  & axi.bready;
         hs_ar = axi.arvalid & axi.arready;
         hs_r  = axi.rvalid  & axi.rready;
         if (hs_aw) last_awaddr = axi.awaddr;
         if (hs_w) begin last_wdata = axi.wdata; last_wstrb = axi.wstrb; end
         if (hs_ar) last_araddr = axi.araddr;
         #1;
         if (hs_b) begin axi.bvalid = 1'b0; b_cnt++; end
         if (hs_r) axi.rvalid = 1'b0;
         if (hs_aw) begin
            axi.awready = 1'b0; aw_cnt = 0; got_aw = 1'b1;
         end else if (axi.awvalid) begin
            axi.awready = (aw_cnt >= aw_delay);
            aw_cnt++;
         end
         if (hs_w) begin
            axi.wready = 1'b0; got_w = 1'b1;
         end else if (axi.wvalid) begin
            axi.wready = 1'b1;
         end
         if (got_aw && got_w && !axi.bvalid) begin
            mem[last_awaddr[3:2]] = last_wdata;
            axi.bvalid = 1'b1;
            axi.bresp  = b_resp_cfg;
            got_aw = 1'b0; got_w = 1'b0;
         end
         if (hs_ar) begin
            axi.arready = 1'b0;
            axi.rvalid  = 1'b1;
            axi.rdata   = mem[last_araddr[3:2]];
            axi.rresp   = 2'b00;
         end else if (axi.arvalid) begin
            axi.arready = !ar_stall;
         end
         if (areset) begin
            got_aw = 1'b0; got_w = 1'b0; aw_cnt = 0;
            axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
         end
      end
   end

   // ---------------- activity monitor ----------------
   int aw_hi, w_hi, ar_hi, done_total;
   initial begin : monitor
      aw_hi = 0; w_hi = 0; ar_hi = 0; done_total = 0;
      forever begin
         @(negedge aclk);
         if (axi.awvalid) aw_hi++;
         if (axi.wvalid)  w_hi++;
         if (axi.arvalid) ar_hi++;
         if (|done)       done_total++;
      end
   end

   // ---------------- scoreboard ----------------
   int n_tests, n_fail;
   logic [31:0] exp_q[$];
   int          gnt_log[$], done_log[$], ready_cyc[$], done_cyc[$];
   logic [31:0] rdata_log[$];
   logic [1:0]  resp_log[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_req(input int i, input logic we, input logic [7:0] a, input logic [31:0] d);
      req_we[i]    = we;
      req_addr[i]  = a;
      req_wdata[i] = d;
   endtask

   // Presents rem0/rem1 requests (valid held high while more remain) and
   // logs grants and completions until n_done completions or budget expiry.
   task automatic run(input int rem0, input int rem1, input int n_done);
      int rem[2];
      int got;
      int budget;
      rem[0] = rem0; rem[1] = rem1; got = 0; budget = 0;
      gnt_log.delete(); done_log.delete(); ready_cyc.delete();
      done_cyc.delete(); rdata_log.delete(); resp_log.delete();
      @(negedge aclk);
      req_valid[0] = (rem[0] > 0);
      req_valid[1] = (rem[1] > 0);
      while (got < n_done && budget < 200) begin
         @(negedge aclk);
         budget++;
         if (req_ready != 2'b00) begin
            check("ready_onehot", 64'($onehot(req_ready)), 64'd1);
            for (int i = 0; i < 2; i++) begin
               if (req_ready[i]) begin
                  gnt_log.push_back(i);
                  ready_cyc.push_back(budget);
                  rem[i]--;
                  req_valid[i] = (rem[i] > 0);
               end
            end
         end
         if (done != 2'b00) begin
            for (int i = 0; i < 2; i++) begin
               if (done[i]) begin
                  done_log.push_back(i);
                  done_cyc.push_back(budget);
                  rdata_log.push_back(rsp_rdata);
                  resp_log.push_back(rsp_resp);
                  got++;
               end
            end
         end
      end
      req_valid = 2'b00;
      check("completions", 64'(got), 64'(n_done));
   endtask

   // ---------------- directed sequence ----------------
   initial begin : stim
      int aw0, w0, ar0, b0, d0, lat;
      n_tests = 0; n_fail = 0;
      aw_delay = 0; ar_stall = 1'b0; b_resp_cfg = 2'b00;
      areset = 1'b1;
      req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge aclk);

      // Reset state
      check("rst_state",     64'(dbg_state), 64'(ST_IDLE));
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_done",      64'(done), 64'd0);
      check("rst_rsp_resp",  64'(rsp_resp), 64'd0);
      check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
      check("rst_valids",    64'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}), 64'd0);
      check("rst_awaddr",    64'(axi.awaddr), 64'd0);
      check("rst_wdata",     64'(axi.wdata), 64'd0);
      check("rst_araddr",    64'(axi.araddr), 64'd0);
      check("wstrb_const",   64'(axi.wstrb), 64'hF);
      check("prot_const",    64'({axi.awprot, axi.arprot}), 64'd0);
      areset = 1'b0;

      // First tie after reset: req0 write 0x0=1, req1 read 0x0
      set_req(0, 1'b1, 8'h00, 32'h0000_0001);
      set_req(1, 1'b0, 8'h00, 32'h0);
      run(1, 1, 2);
      check("tie_first_grant", 64'(gnt_log[0]), 64'd0);
      check("tie_second_grant", 64'(gnt_log[1]), 64'd1);
      check("tie_done_order", 64'(done_log[1]), 64'd1);
      check("tie_rd_data", 64'(rdata_log[1]), 64'h0000_0001);
      check("tie_rd_resp", 64'(resp_log[1]), 64'd0);

      // Both continuously valid: 4 accesses, alternating grants
      set_req(0, 1'b1, 8'h08, 32'h1111_2222);
      set_req(1, 1'b0, 8'h08, 32'h0);
      exp_q = '{32'd0, 32'd1, 32'd0, 32'd1};
      run(2, 2, 4);
      for (int k = 0; k < 4; k++) begin
         check("rr_grant", 64'(gnt_log[k]), 64'(exp_q.pop_front()));
      end
      check("rr_period", 64'(ready_cyc[1] - ready_cyc[0]), 64'd4);
      check("rr_rd_data1", 64'(rdata_log[1]), 64'h1111_2222);
      check("rr_rd_data3", 64'(rdata_log[3]), 64'h1111_2222);

      // Req0 write 0x04, zero-wait slave
      set_req(0, 1'b1, 8'h04, 32'hA5A5_0001);
      run(1, 0, 1);
      check("wr_awaddr", 64'(last_awaddr), 64'h4);
      check("wr_wdata",  64'(last_wdata), 64'hA5A5_0001);
      check("wr_wstrb",  64'(last_wstrb), 64'hF);
      check("wr_done_idx", 64'(done_log[0]), 64'd0);
      lat = done_cyc[0] - ready_cyc[0];
      check("wr_latency", 64'(lat), 64'd2);
      check("wr_resp",  64'(resp_log[0]), 64'd0);
      check("wr_rdata", 64'(rdata_log[0]), 64'd0);

      // AWREADY delayed 3 cycles, byte offset ignored, SLVERR passed back
      aw_delay = 3; b_resp_cfg = 2'b10;
      aw0 = aw_hi; w0 = w_hi; b0 = b_cnt; d0 = done_total;
      set_req(1, 1'b1, 8'h0E, 32'hDEAD_BEEF);
      run(0, 1, 1);
      repeat (3) @(negedge aclk);
      check("awd_aw_cycles", 64'(aw_hi - aw0), 64'd4);
      check("awd_w_cycles",  64'(w_hi - w0), 64'd1);
      check("awd_b_hs",      64'(b_cnt - b0), 64'd1);
      check("awd_done_cnt",  64'(done_total - d0), 64'd1);
      check("awd_awaddr",    64'(last_awaddr), 64'hC);
      check("awd_resp",      64'(resp_log[0]), 64'd2);
      check("awd_done_idx",  64'(done_log[0]), 64'd1);
      aw_delay = 0; b_resp_cfg = 2'b00;

      // Req1 read of 0x10 (word index 4)
      ar0 = ar_hi;
      set_req(1, 1'b0, 8'h10, 32'h0);
      run(0, 1, 1);
      check("oor_done_idx", 64'(done_log[0]), 64'd1);
`ifdef DISP_ARB_ADDR_CHECK_EN
      check("oor_no_ar", 64'(ar_hi - ar0), 64'd0);
      check("oor_latency", 64'(done_cyc[0] - ready_cyc[0]), 64'd0);
      check("oor_resp", 64'(resp_log[0]), 64'd3);
      check("oor_rdata", 64'(rdata_log[0]), 64'd0);
`else
      check("oor_ar_cycles", 64'(ar_hi - ar0), 64'd1);
      check("oor_araddr", 64'(last_araddr), 64'h0);
      check("oor_resp", 64'(resp_log[0]), 64'd0);
      check("oor_rdata", 64'(rdata_log[0]), 64'h0000_0001);
`endif

      // Reset during a stalled read by req0
      ar_stall = 1'b1;
      set_req(0, 1'b0, 8'h04, 32'h0);
      @(negedge aclk);
      req_valid[0] = 1'b1;
      for (int k = 0; k < 10 && req_ready[0] !== 1'b1; k++) @(negedge aclk);
      req_valid[0] = 1'b0;
      check("rst_mid_accept", 64'(req_ready), 64'd1);
      @(negedge aclk);
      check("rst_mid_arvalid_pre", 64'(axi.arvalid), 64'd1);
      areset = 1'b1;
      #1;
      check("rst_mid_arvalid", 64'(axi.arvalid), 64'd0);
      check("rst_mid_state", 64'(dbg_state), 64'(ST_IDLE));
      @(negedge aclk);
      areset = 1'b0; ar_stall = 1'b0;
      d0 = done_total;
      repeat (4) @(negedge aclk);
      check("rst_mid_no_done", 64'(done_total - d0), 64'd0);
      set_req(0, 1'b0, 8'h04, 32'h0);
      set_req(1, 1'b0, 8'h08, 32'h0);
      run(1, 1, 2);
      check("rst_tie_grant", 64'(gnt_log[0]), 64'd0);
      check("rst_rd0_data", 64'(rdata_log[0]), 64'hA5A5_0001);
      check("rst_rd1_data", 64'(rdata_log[1]), 64'h1111_2222);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
